edp_diag_reader: RTL and testbench
==================================

Name: edp_diag_reader

Overview:
- EBUS-side reader for the EDP diagnostic-read path.
- Takes register-read requests from the front-end/console logic and arbitrates for the EBUS.
- Drives DIAG function 12x with a 3-bit select to the EDP, waits for the EDP's registered EBUS driver to settle, captures the 36-bit EBUS data, and returns it over a valid/ready response channel.
- Supports single reads and an 8-register sweep: AR, BR, MQ, FM, BRX, ARX, ADX, AD.

Parameters:
- SETTLE, default 2: clocks DIAG_READ is held before EBUS is sampled (minimum 1).
- GRANT_TIMEOUT, default 255: clocks to wait for ebus_grant before aborting the request.

Ports:
- clk  in  1  EBOX clock.
- rst_n  in  1  Asynchronous active-low reset.
- req_valid  in  1  Request present.
- req_ready  out  1  Reader can accept a request.
- req_sel  in  [0:2]  Register select: 0=AR 1=BR 2=MQ 3=FM 4=BRX 5=ARX 6=ADX 7=AD.
- req_all  in  1  Sweep selects 0..7; req_sel is ignored.
- ebus_req  out  1  EBUS ownership request.
- ebus_grant  in  1  EBUS ownership granted.
- diag_read  out  1  DIAG_READ_FUNC_12x strobe to the EDP.
- diag_func  out  [4:6]  Select presented to the EDP.
- ebus_data  in  [0:35]  EBUS data lines.
- rsp_valid  out  1  Response present.
- rsp_ready  in  1  Consumer accepts the response.
- rsp_sel  out  [0:2]  Select the response belongs to.
- rsp_data  out  [0:35]  Captured word.
- rsp_last  out  1  Final response of a request (always 1 for single reads).
- rsp_err  out  1  Grant timeout; rsp_data is 0.

Behaviour:
- Reset values: all outputs 0 except req_ready=1. State=IDLE. Counters 0.
- State IDLE:
  - req_ready=1.
  - req_valid&req_ready loads cur_sel (0 if req_all, else req_sel) and the all flag.
  - Next state REQ.
- State REQ:
  - ebus_req=1.
  - Timeout counter increments each clock.
  - ebus_grant=1 -> DRIVE, counter cleared.
  - Counter reaching GRANT_TIMEOUT without grant -> ERR.
  - Grant and timeout in the same clock: grant wins.
- State DRIVE:
  - ebus_req=1, diag_read=1, diag_func=cur_sel, all stable.
  - Settle counter counts SETTLE clocks.
  - On the clock the count completes, ebus_data is latched into rsp_data, rsp_sel=cur_sel, state -> RESP.
  - Latency from grant to rsp_valid = SETTLE+1 clocks.
- State RESP:
  - rsp_valid=1; rsp_data/rsp_sel/rsp_last held stable until rsp_ready.
  - diag_read=0 and ebus_req=0 (bus released while waiting).
  - rsp_last = ~all | (cur_sel==7).
  - On rsp_valid&rsp_ready: if rsp_last -> IDLE; else cur_sel+1 -> REQ (re-arbitrate for each register).
  - cur_sel never wraps: the sweep stops after 7.
- State ERR:
  - rsp_valid=1, rsp_err=1, rsp_last=1, rsp_data=0, rsp_sel=cur_sel.
  - On rsp_ready -> IDLE.
  - A timeout mid-sweep aborts the remaining selects.
- Grant loss: ebus_grant dropping during DRIVE restarts DRIVE via REQ; no partial capture.
- req_ready is 0 in every state except IDLE; requests arriving then are held off, not dropped.
- Reset mid-operation: all outputs drop asynchronously, including diag_read and ebus_req; no response is emitted.
- Response path: a single registered stage; no FIFO.

Optional Feature:
- Macro EDP_DIAG_PARITY_EN.
- When defined:
  - Adds input fm_parity_in (1) and output rsp_par_err (1).
  - For sel=3 (FM), parity is computed as XOR of the captured word and compared against fm_parity_in sampled on the same clock.
  - A mismatch sets rsp_par_err with the response.
  - rsp_par_err is 0 for all other selects and in ERR.
- When not defined: neither port exists and there is no parity logic.

Test Plan:
- Single read AR, sel=0: grant tied 1, ebus_data=36'o123456701234 -> diag_read high for 2 clocks with diag_func=0; rsp_valid on clock 3 after grant; rsp_data=36'o123456701234, rsp_last=1, rsp_err=0.
- Sweep, req_all=1: ebus_data = sel*36'o010101010101 -> 8 responses, sels 0..7 in order, correct data each, rsp_last only on sel 7; ebus_req deasserts between responses.
- Backpressure: rsp_ready held 0 for 10 clocks with ebus_data changing -> rsp_data is stable; req_ready=0; diag_read=0 throughout.
- Timeout: ebus_grant=0, GRANT_TIMEOUT=255 -> rsp_err=1, rsp_data=0, rsp_last=1 after 255 clocks; a sweep aborts at the current sel.
- Reset: rst_n asserted during DRIVE -> diag_read and ebus_req go 0 immediately without a clock edge; after release req_ready=1 and no stray rsp_valid.
- EDP_DIAG_PARITY_EN: sel=3, ebus_data=36'o1, fm_parity_in=0 -> rsp_par_err=1. Same with fm_parity_in=1 -> rsp_par_err=0.

Source files
------------

// File: rtl/edp_diag_reader_if.sv
// Bundle of the request, EBUS/EDP and response channels used by the
// EDP diagnostic-read path. The slave modport is the reader itself; the
// master modport is the surrounding logic: the front-end, the bus arbiter,
// the EDP and the response consumer.
// Optional macro EDP_DIAG_PARITY_EN adds fm_parity_in and rsp_par_err.
interface edp_diag_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [0:2]  req_sel;
  logic        req_all;
  logic        ebus_req;
  logic        ebus_grant;
  logic        diag_read;
  logic [4:6]  diag_func;
  logic [0:35] ebus_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:2]  rsp_sel;
  logic [0:35] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
`ifdef EDP_DIAG_PARITY_EN
  logic        fm_parity_in;
  logic        rsp_par_err;

  modport master (
    output req_valid, req_sel, req_all, ebus_grant, ebus_data, rsp_ready, fm_parity_in,
    input  req_ready, ebus_req, diag_read, diag_func, rsp_valid, rsp_sel, rsp_data,
           rsp_last, rsp_err, rsp_par_err
  );

  modport slave (
    input  req_valid, req_sel, req_all, ebus_grant, ebus_data, rsp_ready, fm_parity_in,
    output req_ready, ebus_req, diag_read, diag_func, rsp_valid, rsp_sel, rsp_data,
           rsp_last, rsp_err, rsp_par_err
  );
`else
  modport master (
    output req_valid, req_sel, req_all, ebus_grant, ebus_data, rsp_ready,
    input  req_ready, ebus_req, diag_read, diag_func, rsp_valid, rsp_sel, rsp_data,
           rsp_last, rsp_err
  );

  modport slave (
    input  req_valid, req_sel, req_all, ebus_grant, ebus_data, rsp_ready,
    output req_ready, ebus_req, diag_read, diag_func, rsp_valid, rsp_sel, rsp_data,
           rsp_last, rsp_err
  );
`endif
endinterface

// File: rtl/edp_diag_reader.sv
// EBUS-side reader for the EDP diagnostic-read path. It takes a single read
// or an 8-register sweep (AR, BR, MQ, FM, BRX, ARX, ADX, AD) and arbitrates
// for the EBUS separately for every register. It holds DIAG_READ for SETTLE
// clocks, captures the EBUS word, and returns it through one registered
// valid/ready response stage. A grant that never arrives within
// GRANT_TIMEOUT clocks produces an error response and ends the request.
// Optional macro EDP_DIAG_PARITY_EN enables the FM parity check.
module edp_diag_reader #(
  parameter int SETTLE        = 2,
  parameter int GRANT_TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_n,
  edp_diag_reader_if.slave bus
);

  localparam int TW = $clog2(GRANT_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {IDLE, REQ, DRIVE, RESP, ERR} state_t;

  state_t      state, state_d;
  logic [0:2]  cur_sel, cur_sel_d;
  logic        all_q, all_d;
  logic [TW-1:0] tmo_cnt, tmo_cnt_d;
  logic [SW-1:0] settle_cnt, settle_cnt_d;
  logic [0:35] data_q;
  logic        capture;
  logic        last;

  // A single read is always last; a sweep ends on AD and never wraps.
  assign last = ~all_q | (cur_sel == 3'd7);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Select, sweep flag, counters and the captured word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sel    <= '0;
      all_q      <= 1'b0;
      tmo_cnt    <= '0;
      settle_cnt <= '0;
      data_q     <= '0;
    end else begin
      cur_sel    <= cur_sel_d;
      all_q      <= all_d;
      tmo_cnt    <= tmo_cnt_d;
      settle_cnt <= settle_cnt_d;
      if (capture) data_q <= bus.ebus_data;
    end
  end

  // Next-state and output decode; outputs depend only on state and registers.
  always_comb begin
    state_d       = state;
    cur_sel_d     = cur_sel;
    all_d         = all_q;
    tmo_cnt_d     = tmo_cnt;
    settle_cnt_d  = settle_cnt;
    capture       = 1'b0;
    bus.req_ready = 1'b0;
    bus.ebus_req  = 1'b0;
    bus.diag_read = 1'b0;
    bus.diag_func = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_sel   = '0;
    bus.rsp_data  = '0;
    bus.rsp_last  = 1'b0;
    bus.rsp_err   = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          cur_sel_d    = bus.req_all ? 3'd0 : bus.req_sel;
          all_d        = bus.req_all;
          tmo_cnt_d    = '0;
          settle_cnt_d = '0;
          state_d      = REQ;
        end
      end
      REQ: begin
        bus.ebus_req = 1'b1;
        if (bus.ebus_grant) begin
          tmo_cnt_d    = '0;
          settle_cnt_d = '0;
          state_d      = DRIVE;
        end else if (tmo_cnt == TW'(GRANT_TIMEOUT - 1)) begin
          tmo_cnt_d = '0;
          state_d   = ERR;
        end else begin
          tmo_cnt_d = tmo_cnt + TW'(1);
        end
      end
      DRIVE: begin
        bus.ebus_req  = 1'b1;
        bus.diag_read = 1'b1;
        bus.diag_func = cur_sel;
        if (!bus.ebus_grant) begin
          settle_cnt_d = '0;
          tmo_cnt_d    = '0;
          state_d      = REQ;
        end else if (settle_cnt == SW'(SETTLE - 1)) begin
          capture      = 1'b1;
          settle_cnt_d = '0;
          state_d      = RESP;
        end else begin
          settle_cnt_d = settle_cnt + SW'(1);
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_sel   = cur_sel;
        bus.rsp_data  = data_q;
        bus.rsp_last  = last;
        if (bus.rsp_ready) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            cur_sel_d = cur_sel + 3'd1;
            state_d   = REQ;
          end
        end
      end
      ERR: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = 1'b1;
        bus.rsp_last  = 1'b1;
        bus.rsp_sel   = cur_sel;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef EDP_DIAG_PARITY_EN
  logic par_q;

  // FM word parity is checked against the EDP's parity bit at capture time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       par_q <= 1'b0;
    else if (capture) par_q <= (cur_sel == 3'd3) && ((^bus.ebus_data) != bus.fm_parity_in);
  end

  assign bus.rsp_par_err = (state == RESP) & par_q;
`endif

endmodule

// File: tb/tb_edp_diag_reader.sv
// Self-checking bench for edp_diag_reader. It contains a small EDP model, with
// one register file indexed by diag_func, and a transaction-level scoreboard
// of expected responses. There are table-driven single reads, hand-written
// latency, backpressure, timeout and reset sequences, and a randomized run.
module tb_edp_diag_reader;
  localparam int SETTLE        = 2;
  localparam int GRANT_TIMEOUT = 255;
  localparam logic [47:0] RST_EXP = {1'b1, 47'b0};

  typedef struct {
    logic [2:0]  sel;
    logic [35:0] word;
    logic        parIn;
    logic        expLast;
    logic        expPar;
  } vec_t;

  typedef struct {
    logic [2:0]  sel;
    logic [35:0] data;
    logic        last;
    logic        err;
    logic        par;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  int          nChecks = 0;
  int          nFails  = 0;
  int          rspCount = 0;
  int          grantMode;
  int          readyMode;
  bit          sbOn;
  logic        fmParity;
  logic [35:0] regFile [8];
  logic [63:0] noise;
  rsp_t        expQ [$];
  vec_t        vecs [6];

  edp_diag_reader_if bus ();

  edp_diag_reader #(.SETTLE(SETTLE), .GRANT_TIMEOUT(GRANT_TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bound on the whole run in case the design stalls somewhere unexpected.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: run still active, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // One clock of environment activity: EDP model, arbiter, consumer, scoreboard.
  task automatic tick();
    logic r;
    rsp_t e;
    @(negedge clk);
    noise = {$urandom, $urandom};
    bus.ebus_data = bus.diag_read ? regFile[bus.diag_func] : noise[35:0];
    case (grantMode)
      0:       bus.ebus_grant = 1'b1;
      1:       bus.ebus_grant = ($urandom_range(0, 3) != 0);
      default: bus.ebus_grant = 1'b0;
    endcase
    case (readyMode)
      0:       r = 1'b1;
      1:       r = ($urandom_range(0, 2) != 0);
      default: r = 1'b0;
    endcase
`ifdef EDP_DIAG_PARITY_EN
    bus.fm_parity_in = fmParity;
`endif
    if (bus.rsp_valid) begin
      checkOutput("bus_released", 64'({bus.ebus_req, bus.diag_read, bus.req_ready}), 64'd0);
      if (sbOn && r) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL sb_unexpected: got response sel %0d, required none", bus.rsp_sel);
        end else begin
          e = expQ.pop_front();
          checkOutput("sb_sel",  64'(bus.rsp_sel),  64'(e.sel));
          checkOutput("sb_data", 64'(bus.rsp_data), 64'(e.data));
          checkOutput("sb_last", 64'(bus.rsp_last), 64'(e.last));
          checkOutput("sb_err",  64'(bus.rsp_err),  64'(e.err));
`ifdef EDP_DIAG_PARITY_EN
          checkOutput("sb_par",  64'(bus.rsp_par_err), 64'(e.par));
`endif
        end
      end
      if (r) rspCount++;
    end
    bus.rsp_ready = r;
  endtask

  // Expected responses from the read rules; errAt marks where a grant timeout ends the request.
  task automatic modelPush(input logic [2:0] sel, input logic all, input int errAt);
    rsp_t e;
    int   first;
    int   lastSel;
    bit   done;
    first   = all ? 0 : int'(sel);
    lastSel = all ? 7 : int'(sel);
    done    = 1'b0;
    for (int s = first; s <= lastSel; s++) begin
      if (!done) begin
        e.sel = 3'(s);
        if (s == errAt) begin
          e.data = '0;
          e.last = 1'b1;
          e.err  = 1'b1;
          e.par  = 1'b0;
          done   = 1'b1;
        end else begin
          e.data = regFile[s];
          e.last = (s == lastSel);
          e.err  = 1'b0;
          e.par  = (s == 3) && ((^regFile[s]) != fmParity);
        end
        expQ.push_back(e);
      end
    end
  endtask

  task automatic issue(input logic [2:0] sel, input logic all);
    int k = 0;
    while (!bus.req_ready && k < 3000) begin
      tick();
      k++;
    end
    if (!bus.req_ready) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL issue_wait: req_ready=%0d, required 1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_sel   = sel;
    bus.req_all   = all;
    tick();
    bus.req_valid = 1'b0;
    bus.req_sel   = 3'($urandom);
    bus.req_all   = 1'b0;
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while ((expQ.size() != 0 || !bus.req_ready) && k < limit) begin
      tick();
      k++;
    end
    checkOutput("drain_queue", 64'(expQ.size()), 64'd0);
    checkOutput("drain_ready", 64'(bus.req_ready), 64'd1);
  endtask

  task automatic waitValid(input int limit, output int n);
    n = 0;
    while (!bus.rsp_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  // One table vector: single read held under backpressure, checked, then released.
  task automatic applyStimulus(input vec_t v);
    int n;
    readyMode      = 2;
    regFile[v.sel] = v.word;
    fmParity       = v.parIn;
    issue(v.sel, 1'b0);
    waitValid(50, n);
    checkOutput("vec_valid", 64'(bus.rsp_valid), 64'd1);
    checkOutput("vec_sel",   64'(bus.rsp_sel),   64'(v.sel));
    checkOutput("vec_data",  64'(bus.rsp_data),  64'(v.word));
    checkOutput("vec_last",  64'(bus.rsp_last),  64'(v.expLast));
    checkOutput("vec_err",   64'(bus.rsp_err),   64'd0);
`ifdef EDP_DIAG_PARITY_EN
    checkOutput("vec_par",   64'(bus.rsp_par_err), 64'(v.expPar));
`endif
    readyMode = 0;
    drain(50);
  endtask

  initial begin
    int n;
    int hi;
    int k;
    int base;
    bit funcOk;

    rst_n         = 1'b0;
    grantMode     = 0;
    readyMode     = 0;
    sbOn          = 1'b0;
    fmParity      = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_sel   = '0;
    bus.req_all   = 1'b0;
    bus.ebus_grant = 1'b0;
    bus.ebus_data = '0;
    bus.rsp_ready = 1'b0;
`ifdef EDP_DIAG_PARITY_EN
    bus.fm_parity_in = 1'b0;
`endif
    for (int s = 0; s < 8; s++) regFile[s] = '0;

    vecs[0] = '{sel: 3'd0, word: 36'o123456701234, parIn: 1'b0, expLast: 1'b1, expPar: 1'b0};
    vecs[1] = '{sel: 3'd7, word: 36'o777777777777, parIn: 1'b0, expLast: 1'b1, expPar: 1'b0};
    vecs[2] = '{sel: 3'd3, word: 36'o000000000001, parIn: 1'b0, expLast: 1'b1, expPar: 1'b1};
    vecs[3] = '{sel: 3'd3, word: 36'o000000000001, parIn: 1'b1, expLast: 1'b1, expPar: 1'b0};
    vecs[4] = '{sel: 3'd5, word: 36'o525252525252, parIn: 1'b0, expLast: 1'b1, expPar: 1'b0};
    vecs[5] = '{sel: 3'd1, word: 36'o000000000000, parIn: 1'b1, expLast: 1'b1, expPar: 1'b0};

    #12;
    checkOutput("reset_outputs",
                64'({bus.req_ready, bus.ebus_req, bus.diag_read, bus.diag_func, bus.rsp_valid,
                     bus.rsp_sel, bus.rsp_data, bus.rsp_last, bus.rsp_err}),
                64'(RST_EXP));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    $display("[TB] single read AR: latency and backpressure");
    regFile[0] = 36'o123456701234;
    sbOn       = 1'b1;
    readyMode  = 2;
    grantMode  = 0;
    modelPush(3'd0, 1'b0, -1);
    issue(3'd0, 1'b0);
    n = 0;
    hi = 0;
    funcOk = 1'b1;
    while (!bus.rsp_valid && n < 50) begin
      if (bus.diag_read) begin
        hi++;
        if (bus.diag_func != 3'd0) funcOk = 1'b0;
      end
      tick();
      n++;
    end
    checkOutput("ar_latency",     64'(n),      64'(SETTLE + 1));
    checkOutput("ar_read_clocks", 64'(hi),     64'(SETTLE));
    checkOutput("ar_func",        64'(funcOk), 64'd1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_valid", 64'(bus.rsp_valid), 64'd1);
      checkOutput("bp_data",  64'(bus.rsp_data),  64'(36'o123456701234));
      tick();
    end
    readyMode = 0;
    drain(50);

    $display("[TB] table-driven single reads");
    sbOn = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    $display("[TB] full sweep");
    sbOn = 1'b1;
    fmParity = 1'b0;
    for (int s = 0; s < 8; s++) regFile[s] = 36'(s) * 36'o010101010101;
    readyMode = 1;
    grantMode = 0;
    base = rspCount;
    modelPush(3'd0, 1'b1, -1);
    issue(3'd5, 1'b1);
    drain(500);
    checkOutput("sweep_count", 64'(rspCount - base), 64'd8);

    $display("[TB] grant timeout, single read");
    grantMode = 2;
    readyMode = 0;
    modelPush(3'd5, 1'b0, 5);
    issue(3'd5, 1'b0);
    waitValid(400, n);
    checkOutput("tmo_latency", 64'(n), 64'(GRANT_TIMEOUT));
    drain(20);

    $display("[TB] grant timeout in the middle of a sweep");
    grantMode = 0;
    readyMode = 0;
    base = rspCount;
    modelPush(3'd0, 1'b1, 3);
    issue(3'd0, 1'b1);
    k = 0;
    while (rspCount < base + 3 && k < 200) begin
      tick();
      k++;
    end
    grantMode = 2;
    drain(600);
    checkOutput("tmo_sweep_count", 64'(rspCount - base), 64'd4);

    $display("[TB] randomized requests");
    grantMode = 1;
    readyMode = 1;
    for (int i = 0; i < 25; i++) begin
      logic [2:0] rs;
      logic       ra;
      for (int s = 0; s < 8; s++) begin
        noise      = {$urandom, $urandom};
        regFile[s] = noise[35:0];
      end
      fmParity = 1'($urandom);
      rs = 3'($urandom);
      ra = ($urandom_range(0, 3) == 0);
      modelPush(rs, ra, -1);
      issue(rs, ra);
      drain(2000);
    end

    $display("[TB] reset during DRIVE");
    grantMode = 0;
    readyMode = 0;
    issue(3'd2, 1'b1);
    k = 0;
    while (!bus.diag_read && k < 20) begin
      tick();
      k++;
    end
    checkOutput("rst_pre_drive", 64'(bus.diag_read), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async", 64'({bus.diag_read, bus.ebus_req, bus.rsp_valid}), 64'd0);
    checkOutput("rst_ready", 64'(bus.req_ready), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("post_rst_idle", 64'({bus.req_ready, bus.rsp_valid}), 64'b10);
    end
    regFile[4] = 36'o444444444444;
    modelPush(3'd4, 1'b0, -1);
    issue(3'd4, 1'b0);
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
